// File: rtl/din_debouncer.sv
// Debouncer for a raw asynchronous input: 2-flop synchronizer, stability counter
// and a 4-state qualify FSM producing a clean level plus one-cycle rise/fall strobes.
module din_debouncer #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned CNT_WIDTH     = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall,
  output logic busy
);

  localparam logic [1:0] IDLE_LOW  = 2'd0;
  localparam logic [1:0] CHK_HIGH  = 2'd1;
  localparam logic [1:0] IDLE_HIGH = 2'd2;
  localparam logic [1:0] CHK_LOW   = 2'd3;

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  logic                 sync1;
  logic                 sync2;
  logic [1:0]           state;
  logic [1:0]           state_nxt;
  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] cnt_nxt;
  logic                 dout_nxt;
  logic                 rise_nxt;
  logic                 fall_nxt;
  logic                 busy_nxt;

  // Two-flop synchronizer; only sync2 is seen by the FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
    end
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE_LOW;
      cnt   <= '0;
      dout  <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      dout  <= dout_nxt;
      rise  <= rise_nxt;
      fall  <= fall_nxt;
      busy  <= busy_nxt;
    end
  end

  // Next-state and next-output logic; a bounce inside a CHK state restarts from zero.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = '0;
    dout_nxt  = dout;
    rise_nxt  = 1'b0;
    fall_nxt  = 1'b0;
    case (state)
      IDLE_LOW: begin
        if (sync2) begin
          state_nxt = CHK_HIGH;
          cnt_nxt   = CNT_ONE;
        end
      end
      CHK_HIGH: begin
        if (!sync2) begin
          state_nxt = IDLE_LOW;
        end else if (cnt == CNT_LAST) begin
          state_nxt = IDLE_HIGH;
          dout_nxt  = 1'b1;
          rise_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      IDLE_HIGH: begin
        if (!sync2) begin
          state_nxt = CHK_LOW;
          cnt_nxt   = CNT_ONE;
        end
      end
      CHK_LOW: begin
        if (sync2) begin
          state_nxt = IDLE_HIGH;
        end else if (cnt == CNT_LAST) begin
          state_nxt = IDLE_LOW;
          dout_nxt  = 1'b0;
          fall_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      default: begin
        state_nxt = IDLE_LOW;
        dout_nxt  = 1'b0;
      end
    endcase
    busy_nxt = (state_nxt == CHK_HIGH) || (state_nxt == CHK_LOW);
  end

endmodule

// File: tb/tb_din_debouncer.sv
// Directed bench for din_debouncer: each edge compares {dout,rise,fall,busy}
// against hand-derived nibble patterns (nibble 0 = first edge after the stimulus change).
module tb_din_debouncer;

  logic clk;
  logic rst_n;
  logic din;
  logic dout;
  logic rise;
  logic fall;
  logic busy;

  int unsigned n_vec;
  int unsigned n_err;

  din_debouncer #(
    .STABLE_CYCLES(4),
    .CNT_WIDTH    (8)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (din),
    .dout (dout),
    .rise (rise),
    .fall (fall),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got {dout,rise,fall,busy}=%b expected %b", tag, got, exp);
    end
  endtask

  // Check n consecutive edges, sampling 1 ns after each rising edge.
  task automatic run_edges(input string tag, input int n, input logic [31:0] pat);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("%s_e%0d", tag, i + 1), {dout, rise, fall, busy}, pat[i*4 +: 4]);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    din   = 1'b0;

    run_edges("reset", 3, 32'h0);

    // Clean rise: busy from edge 3 to 5, dout/rise at edge 6.
    @(negedge clk);
    rst_n = 1'b1;
    din   = 1'b1;
    run_edges("rise", 8, 32'h88C11100);

    // Clean fall: dout drops with a fall strobe at edge 6.
    @(negedge clk);
    din = 1'b0;
    run_edges("fall", 8, 32'h00299988);

    // Three-sample glitch is rejected.
    @(negedge clk);
    din = 1'b1;
    run_edges("glitch_a", 3, 32'h100);
    @(negedge clk);
    din = 1'b0;
    run_edges("glitch_b", 5, 32'h00011);

    // Bounce 1,0,1 then settle high: single rise 6 edges after settle.
    @(negedge clk);
    din = 1'b1;
    run_edges("bounce_a", 1, 32'h0);
    @(negedge clk);
    din = 1'b0;
    run_edges("bounce_b", 1, 32'h0);
    @(negedge clk);
    din = 1'b1;
    run_edges("bounce_c", 8, 32'h88C11101);

    // Asynchronous reset clears a committed high level without a clock edge.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("async_rst", {dout, rise, fall, busy}, 4'h0);
    run_edges("rst_hold", 2, 32'h0);

    // din high at release qualifies as a normal rise; reset mid-qualification aborts it.
    @(negedge clk);
    rst_n = 1'b1;
    run_edges("midq_a", 4, 32'h1100);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midq_rst", {dout, rise, fall, busy}, 4'h0);
    run_edges("midq_hold", 1, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    run_edges("midq_req", 8, 32'h88C11100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
